// File: rtl/pe_l1_axi_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : pe_l1_axi_arbiter_if
// Description : Bundle of the cache-facing (s_*) and fabric-facing (m_*)
//               AXI channels around the PE L1 AXI arbiter.
//               slave  : the arbiter's view of the bundle.
//               master : the environment's view (caches plus fabric).
// Revision    : 1.0 - initial release
// ============================================================================
interface pe_l1_axi_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int ADR_W   = 32
);
  // Cache side, one slice per requester
  logic [NUM_REQ*ADR_W-1:0] s_araddr;
  logic [NUM_REQ*8-1:0]     s_arlen;
  logic [NUM_REQ-1:0]       s_arvalid;
  logic [NUM_REQ-1:0]       s_arready;
  logic [31:0]              s_rdata;
  logic [NUM_REQ-1:0]       s_rvalid;
  logic                     s_rlast;
  logic [1:0]               s_rresp;
  logic [NUM_REQ-1:0]       s_rready;
  logic [NUM_REQ*ADR_W-1:0] s_awaddr;
  logic [NUM_REQ*8-1:0]     s_awlen;
  logic [NUM_REQ-1:0]       s_awvalid;
  logic [NUM_REQ-1:0]       s_awready;
  logic [NUM_REQ*32-1:0]    s_wdata;
  logic [NUM_REQ*4-1:0]     s_wstrb;
  logic [NUM_REQ-1:0]       s_wlast;
  logic [NUM_REQ-1:0]       s_wvalid;
  logic [NUM_REQ-1:0]       s_wready;
  logic [1:0]               s_bresp;
  logic [NUM_REQ-1:0]       s_bvalid;
  logic [NUM_REQ-1:0]       s_bready;

  // Fabric side, single shared master port
  logic [ADR_W-1:0]         m_araddr;
  logic [7:0]               m_arlen;
  logic                     m_arvalid;
  logic                     m_arready;
  logic [31:0]              m_rdata;
  logic                     m_rvalid;
  logic                     m_rlast;
  logic [1:0]               m_rresp;
  logic                     m_rready;
  logic [ADR_W-1:0]         m_awaddr;
  logic [7:0]               m_awlen;
  logic                     m_awvalid;
  logic                     m_awready;
  logic [31:0]              m_wdata;
  logic [3:0]               m_wstrb;
  logic                     m_wlast;
  logic                     m_wvalid;
  logic                     m_wready;
  logic [1:0]               m_bresp;
  logic                     m_bvalid;
  logic                     m_bready;

  modport slave (
    input  s_araddr, s_arlen, s_arvalid, s_rready,
    input  s_awaddr, s_awlen, s_awvalid, s_wdata, s_wstrb, s_wlast, s_wvalid, s_bready,
    output s_arready, s_rdata, s_rvalid, s_rlast, s_rresp,
    output s_awready, s_wready, s_bresp, s_bvalid,
    output m_araddr, m_arlen, m_arvalid, m_rready,
    output m_awaddr, m_awlen, m_awvalid, m_wdata, m_wstrb, m_wlast, m_wvalid, m_bready,
    input  m_arready, m_rdata, m_rvalid, m_rlast, m_rresp,
    input  m_awready, m_wready, m_bresp, m_bvalid
  );

  modport master (
    output s_araddr, s_arlen, s_arvalid, s_rready,
    output s_awaddr, s_awlen, s_awvalid, s_wdata, s_wstrb, s_wlast, s_wvalid, s_bready,
    input  s_arready, s_rdata, s_rvalid, s_rlast, s_rresp,
    input  s_awready, s_wready, s_bresp, s_bvalid,
    input  m_araddr, m_arlen, m_arvalid, m_rready,
    input  m_awaddr, m_awlen, m_awvalid, m_wdata, m_wstrb, m_wlast, m_wvalid, m_bready,
    output m_arready, m_rdata, m_rvalid, m_rlast, m_rresp,
    output m_awready, m_wready, m_bresp, m_bvalid
  );
endinterface
`default_nettype wire

// File: rtl/pe_l1_axi_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : pe_l1_axi_arbiter
// Description : Round-robin arbiter sharing one AXI master port among
//               NUM_REQ PE L1 caches. One whole transaction (read refill or
//               write-back) owns the port at a time; the granted cache's
//               channels are muxed combinationally onto the master port.
// Revision    : 1.0 - initial release
// ============================================================================
module pe_l1_axi_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADR_W   = 32,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  pe_l1_axi_arbiter_if.slave  bus,
  output logic [ID_W-1:0]     grant_id,
  output logic                busy
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR_ADDR = 3'd3,
    WR_DATA = 3'd4,
    WR_RESP = 3'd5
  } state_t;

  // Search pointer after reset sits on the last requester so requester 0 wins first
  localparam logic [ID_W-1:0] C_LAST_RST = ID_W'(NUM_REQ - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ID_W-1:0]   r_grant_id;
  logic [ID_W-1:0]   w_grant_id_nxt;
  logic [ID_W-1:0]   r_last_grant;
  logic [ID_W-1:0]   w_last_grant_nxt;
  logic              r_is_write;
  logic              w_is_write_nxt;

  logic [NUM_REQ-1:0] w_req;
  logic               w_rr_found;
  logic [ID_W-1:0]    w_rr_winner;
  logic               w_rr_is_write;

  logic [NUM_REQ-1:0] w_gnt_onehot;
  logic [ADR_W-1:0]   w_sel_araddr;
  logic [7:0]         w_sel_arlen;
  logic               w_sel_arvalid;
  logic               w_sel_rready;
  logic [ADR_W-1:0]   w_sel_awaddr;
  logic [7:0]         w_sel_awlen;
  logic               w_sel_awvalid;
  logic [31:0]        w_sel_wdata;
  logic [3:0]         w_sel_wstrb;
  logic               w_sel_wlast;
  logic               w_sel_wvalid;
  logic               w_sel_bready;

  logic w_rd_addr_ph;
  logic w_rd_data_ph;
  logic w_wr_addr_ph;
  logic w_wr_data_ph;
  logic w_wr_resp_ph;

  logic w_ar_hs;
  logic w_r_last_hs;
  logic w_aw_hs;
  logic w_w_last_hs;
  logic w_b_hs;

  // A requester wants the port if it has either a refill or a write-back pending
  assign w_req = bus.s_arvalid | bus.s_awvalid;

  // Round-robin pick: first requesting index after the previous winner
  always_comb begin : rr_pick
    int idx;
    idx           = 0;
    w_rr_found    = 1'b0;
    w_rr_winner   = '0;
    w_rr_is_write = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(r_last_grant) + k) % NUM_REQ;
      if (!w_rr_found && w_req[idx[ID_W-1:0]]) begin
        w_rr_found    = 1'b1;
        w_rr_winner   = idx[ID_W-1:0];
        // A pending write-back always goes ahead of the same cache's refill
        w_rr_is_write = bus.s_awvalid[idx[ID_W-1:0]];
      end
    end
  end

  // Select the granted requester's slices for the master-side mux
  always_comb begin : gnt_sel
    w_gnt_onehot  = '0;
    w_sel_araddr  = '0;
    w_sel_arlen   = '0;
    w_sel_arvalid = 1'b0;
    w_sel_rready  = 1'b0;
    w_sel_awaddr  = '0;
    w_sel_awlen   = '0;
    w_sel_awvalid = 1'b0;
    w_sel_wdata   = '0;
    w_sel_wstrb   = '0;
    w_sel_wlast   = 1'b0;
    w_sel_wvalid  = 1'b0;
    w_sel_bready  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_grant_id == ID_W'(i)) begin
        w_gnt_onehot[i] = 1'b1;
        w_sel_araddr    = bus.s_araddr[i*ADR_W +: ADR_W];
        w_sel_arlen     = bus.s_arlen[i*8 +: 8];
        w_sel_arvalid   = bus.s_arvalid[i];
        w_sel_rready    = bus.s_rready[i];
        w_sel_awaddr    = bus.s_awaddr[i*ADR_W +: ADR_W];
        w_sel_awlen     = bus.s_awlen[i*8 +: 8];
        w_sel_awvalid   = bus.s_awvalid[i];
        w_sel_wdata     = bus.s_wdata[i*32 +: 32];
        w_sel_wstrb     = bus.s_wstrb[i*4 +: 4];
        w_sel_wlast     = bus.s_wlast[i];
        w_sel_wvalid    = bus.s_wvalid[i];
        w_sel_bready    = bus.s_bready[i];
      end
    end
  end

  // Phase decode; the transaction kind qualifies which channel set is live
  assign w_rd_addr_ph = (r_state == RD_ADDR) && !r_is_write;
  assign w_rd_data_ph = (r_state == RD_DATA) && !r_is_write;
  assign w_wr_addr_ph = (r_state == WR_ADDR) &&  r_is_write;
  assign w_wr_data_ph = (r_state == WR_DATA) &&  r_is_write;
  assign w_wr_resp_ph = (r_state == WR_RESP) &&  r_is_write;

  // Read address channel
  assign bus.m_araddr  = w_sel_araddr;
  assign bus.m_arlen   = w_sel_arlen;
  assign bus.m_arvalid = w_rd_addr_ph & w_sel_arvalid;
  assign bus.s_arready = w_gnt_onehot & {NUM_REQ{w_rd_addr_ph & bus.m_arready}};

  // Read data channel: payload broadcast, valid steered to the owner only
  assign bus.s_rdata  = bus.m_rdata;
  assign bus.s_rlast  = bus.m_rlast;
  assign bus.s_rresp  = bus.m_rresp;
  assign bus.s_rvalid = w_gnt_onehot & {NUM_REQ{w_rd_data_ph & bus.m_rvalid}};
  assign bus.m_rready = w_rd_data_ph & w_sel_rready;

  // Write address channel
  assign bus.m_awaddr  = w_sel_awaddr;
  assign bus.m_awlen   = w_sel_awlen;
  assign bus.m_awvalid = w_wr_addr_ph & w_sel_awvalid;
  assign bus.s_awready = w_gnt_onehot & {NUM_REQ{w_wr_addr_ph & bus.m_awready}};

  // Write data channel
  assign bus.m_wdata  = w_sel_wdata;
  assign bus.m_wstrb  = w_sel_wstrb;
  assign bus.m_wlast  = w_sel_wlast;
  assign bus.m_wvalid = w_wr_data_ph & w_sel_wvalid;
  assign bus.s_wready = w_gnt_onehot & {NUM_REQ{w_wr_data_ph & bus.m_wready}};

  // Write response channel
  assign bus.s_bresp  = bus.m_bresp;
  assign bus.s_bvalid = w_gnt_onehot & {NUM_REQ{w_wr_resp_ph & bus.m_bvalid}};
  assign bus.m_bready = w_wr_resp_ph & w_sel_bready;

  // Handshakes observed on the master port
  assign w_ar_hs     = bus.m_arvalid & bus.m_arready;
  assign w_r_last_hs = bus.m_rvalid & bus.m_rready & bus.m_rlast;
  assign w_aw_hs     = bus.m_awvalid & bus.m_awready;
  assign w_w_last_hs = bus.m_wvalid & bus.m_wready & bus.m_wlast;
  assign w_b_hs      = bus.m_bvalid & bus.m_bready;

  // Next-state logic: grant in IDLE, then walk the granted transaction's phases
  always_comb begin : fsm_next
    w_state_nxt      = r_state;
    w_grant_id_nxt   = r_grant_id;
    w_last_grant_nxt = r_last_grant;
    w_is_write_nxt   = r_is_write;
    case (r_state)
      IDLE: begin
        if (w_rr_found) begin
          w_grant_id_nxt   = w_rr_winner;
          w_last_grant_nxt = w_rr_winner;
          w_is_write_nxt   = w_rr_is_write;
          w_state_nxt      = w_rr_is_write ? WR_ADDR : RD_ADDR;
        end
      end
      RD_ADDR: if (w_ar_hs)     w_state_nxt = RD_DATA;
      RD_DATA: if (w_r_last_hs) w_state_nxt = IDLE;
      WR_ADDR: if (w_aw_hs)     w_state_nxt = WR_DATA;
      WR_DATA: if (w_w_last_hs) w_state_nxt = WR_RESP;
      WR_RESP: if (w_b_hs)      w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State and grant registers; reset abandons any in-flight burst
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_grant_id   <= '0;
      r_last_grant <= C_LAST_RST;
      r_is_write   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_grant_id   <= w_grant_id_nxt;
      r_last_grant <= w_last_grant_nxt;
      r_is_write   <= w_is_write_nxt;
    end
  end

  assign grant_id = r_grant_id;
  assign busy     = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_pe_l1_axi_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_pe_l1_axi_arbiter
// Description : Self-checking bench for pe_l1_axi_arbiter (2 requesters).
//               Table of single-transaction vectors plus hand-written
//               multi-cycle sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pe_l1_axi_arbiter;

  localparam int NUM_REQ = 2;
  localparam int ADR_W   = 32;
  localparam int ID_W    = 1;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [ID_W-1:0] grant_id;
  logic            busy;

  int n_checks = 0;
  int n_errors = 0;

  pe_l1_axi_arbiter_if #(.NUM_REQ(NUM_REQ), .ADR_W(ADR_W)) bus ();

  pe_l1_axi_arbiter #(.NUM_REQ(NUM_REQ), .ADR_W(ADR_W), .ID_W(ID_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus.slave),
    .grant_id (grant_id),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Beats recorded on the cache side (R) and master side (W); sampled mid-cycle
  logic [31:0] rq0[$];
  logic [31:0] rq1[$];
  logic [31:0] wq_data[$];
  logic        wq_last[$];

  always @(negedge clk) begin
    if (bus.s_rvalid[0] && bus.s_rready[0]) rq0.push_back(bus.s_rdata);
    if (bus.s_rvalid[1] && bus.s_rready[1]) rq1.push_back(bus.s_rdata);
    if (bus.m_wvalid && bus.m_wready) begin
      wq_data.push_back(bus.m_wdata);
      wq_last.push_back(bus.m_wlast);
    end
  end

  typedef struct {
    logic [1:0]      arv;
    logic [1:0]      awv;
    logic [ID_W-1:0] gnt;
    logic            wr;
    logic [31:0]     addr;
    logic [7:0]      len;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] onehot(input int r);
    logic [1:0] v;
    v = 2'b01;
    return v << r;
  endfunction

  function automatic logic [31:0] ar_addr(input int r);
    return (r == 0) ? 32'h0000_1000 : 32'h0000_1100;
  endfunction

  // Compare the beats a cache received against base, base+1, ...
  task automatic check_rd(input int r, input logic [31:0] base, input int n);
    logic [31:0] q[$];
    if (r == 0) begin q = rq0; rq0.delete(); end
    else        begin q = rq1; rq1.delete(); end
    chk("rd_beat_count", q.size(), n);
    for (int i = 0; i < q.size() && i < n; i++) chk("rd_beat_data", q[i], base + i);
  endtask

  // Called one cycle after the grant edge; plays fabric and cache for a read
  task automatic read_txn(input int r, input logic [31:0] addr, input logic [7:0] len,
                          input logic [31:0] base, input int stall, input int abort_beat);
    int beat;
    int cyc;
    int stall_left;
    logic acc;
    chk("rd_busy", busy, 1);
    chk("rd_grant", grant_id, r);
    chk("rd_arvalid", bus.m_arvalid, 1);
    chk("rd_awvalid_idle", bus.m_awvalid, 0);
    chk("rd_araddr", bus.m_araddr, addr);
    chk("rd_arlen", bus.m_arlen, len);
    bus.m_arready = 1'b1;
    #1;
    chk("rd_s_arready", bus.s_arready, onehot(r));
    tick();
    bus.s_arvalid[r] = 1'b0;
    bus.m_arready    = 1'b0;
    beat = 0;
    cyc = 0;
    stall_left = stall;
    while (beat <= int'(len) && cyc < 200) begin
      if (beat == abort_beat) return;
      bus.m_rvalid = 1'b1;
      bus.m_rdata  = base + beat;
      bus.m_rlast  = (beat == int'(len));
      bus.m_rresp  = 2'b00;
      if (stall_left > 0 && beat == 1) begin
        bus.s_rready[r] = 1'b0;
        stall_left--;
      end else begin
        bus.s_rready[r] = 1'b1;
      end
      #1;
      chk("rd_s_rvalid", bus.s_rvalid, onehot(r));
      chk("rd_m_rready", bus.m_rready, bus.s_rready[r]);
      acc = bus.m_rready;
      tick();
      if (acc) beat++;
      cyc++;
    end
    bus.m_rvalid     = 1'b0;
    bus.m_rlast      = 1'b0;
    bus.s_rready[r]  = 1'b0;
    if (cyc >= 200) chk("rd_timeout", 1, 0);
    chk("rd_done_busy", busy, 0);
  endtask

  // Called one cycle after the grant edge; plays fabric and cache for a write
  task automatic write_txn(input int r, input logic [31:0] addr, input logic [7:0] len,
                           input logic [31:0] base, input bit toggle);
    int beat;
    int cyc;
    logic acc;
    logic [3:0] st;
    chk("wr_busy", busy, 1);
    chk("wr_grant", grant_id, r);
    chk("wr_awvalid", bus.m_awvalid, 1);
    chk("wr_arvalid_idle", bus.m_arvalid, 0);
    chk("wr_awaddr", bus.m_awaddr, addr);
    chk("wr_awlen", bus.m_awlen, len);
    bus.m_awready = 1'b1;
    #1;
    chk("wr_s_awready", bus.s_awready, onehot(r));
    tick();
    bus.s_awvalid[r] = 1'b0;
    bus.m_awready    = 1'b0;
    wq_data.delete();
    wq_last.delete();
    beat = 0;
    cyc = 0;
    while (beat <= int'(len) && cyc < 200) begin
      st = (beat % 2 == 0) ? 4'hF : 4'h3;
      bus.s_wdata[r*32 +: 32] = base + beat;
      bus.s_wstrb[r*4 +: 4]   = st;
      bus.s_wlast[r]          = (beat == int'(len));
      bus.s_wvalid[r]         = 1'b1;
      bus.m_wready            = toggle ? (cyc % 2 == 1) : 1'b1;
      #1;
      chk("wr_m_wvalid", bus.m_wvalid, 1);
      chk("wr_m_wdata", bus.m_wdata, base + beat);
      chk("wr_m_wstrb", bus.m_wstrb, st);
      chk("wr_s_wready", bus.s_wready, bus.m_wready ? onehot(r) : 2'b00);
      acc = bus.s_wready[r];
      tick();
      if (acc) beat++;
      cyc++;
    end
    bus.s_wvalid[r] = 1'b0;
    bus.s_wlast[r]  = 1'b0;
    bus.m_wready    = 1'b0;
    if (cyc >= 200) chk("wr_timeout", 1, 0);
    chk("wr_beat_count", wq_data.size(), int'(len) + 1);
    for (int i = 0; i < wq_data.size(); i++) begin
      chk("wr_beat_data", wq_data[i], base + i);
      chk("wr_beat_last", wq_last[i], (i == int'(len)));
    end
    chk("wr_resp_busy", busy, 1);
    chk("wr_resp_wvalid", bus.m_wvalid, 0);
    bus.m_bvalid    = 1'b1;
    bus.m_bresp     = 2'b00;
    bus.s_bready[r] = 1'b1;
    #1;
    chk("wr_s_bvalid", bus.s_bvalid, onehot(r));
    chk("wr_m_bready", bus.m_bready, 1);
    tick();
    bus.m_bvalid    = 1'b0;
    bus.s_bready[r] = 1'b0;
    chk("wr_done_busy", busy, 0);
  endtask

  // Watchdog: a hung handshake must still end the run
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{2'b01, 2'b00, 1'b0, 1'b0, 32'h0000_1000, 8'd1};
    tbl[1] = '{2'b01, 2'b00, 1'b0, 1'b0, 32'h0000_1000, 8'd0};
    tbl[2] = '{2'b11, 2'b00, 1'b1, 1'b0, 32'h0000_1100, 8'd2};
    tbl[3] = '{2'b10, 2'b10, 1'b1, 1'b1, 32'h0000_2040, 8'd1};
    tbl[4] = '{2'b11, 2'b01, 1'b0, 1'b1, 32'h0000_2000, 8'd0};
    tbl[5] = '{2'b00, 2'b11, 1'b1, 1'b1, 32'h0000_2040, 8'd3};
    tbl[6] = '{2'b10, 2'b00, 1'b1, 1'b0, 32'h0000_1100, 8'd1};
    tbl[7] = '{2'b00, 2'b01, 1'b0, 1'b1, 32'h0000_2000, 8'd2};

    rst_n         = 1'b0;
    bus.s_araddr  = {32'h0000_1100, 32'h0000_1000};
    bus.s_awaddr  = {32'h0000_2040, 32'h0000_2000};
    bus.s_arlen   = '0;
    bus.s_awlen   = '0;
    bus.s_arvalid = '0;
    bus.s_awvalid = '0;
    bus.s_rready  = '0;
    bus.s_wdata   = '0;
    bus.s_wstrb   = '0;
    bus.s_wlast   = '0;
    bus.s_wvalid  = '0;
    bus.s_bready  = '0;
    bus.m_arready = 1'b0;
    bus.m_rdata   = '0;
    bus.m_rvalid  = 1'b0;
    bus.m_rlast   = 1'b0;
    bus.m_rresp   = '0;
    bus.m_awready = 1'b0;
    bus.m_wready  = 1'b0;
    bus.m_bresp   = '0;
    bus.m_bvalid  = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Reset state
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_m_arvalid", bus.m_arvalid, 0);
    chk("rst_m_awvalid", bus.m_awvalid, 0);
    chk("rst_m_wvalid", bus.m_wvalid, 0);
    chk("rst_m_rready", bus.m_rready, 0);
    chk("rst_m_bready", bus.m_bready, 0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk("idle_busy", busy, 0);

    // Table of single transactions, round-robin pointer carried between rows
    for (int v = 0; v < 8; v++) begin
      bus.s_arlen   = {tbl[v].len, tbl[v].len};
      bus.s_awlen   = {tbl[v].len, tbl[v].len};
      bus.s_arvalid = tbl[v].arv;
      bus.s_awvalid = tbl[v].awv;
      tick();
      chk("vec_grant", grant_id, tbl[v].gnt);
      chk("vec_kind_aw", bus.m_awvalid, tbl[v].wr);
      chk("vec_kind_ar", bus.m_arvalid, !tbl[v].wr);
      if (tbl[v].wr)
        write_txn(int'(tbl[v].gnt), tbl[v].addr, tbl[v].len, 32'hA000_0000 + (v << 8), 1'b0);
      else begin
        read_txn(int'(tbl[v].gnt), tbl[v].addr, tbl[v].len, 32'hB000_0000 + (v << 8), 0, -1);
        check_rd(int'(tbl[v].gnt), 32'hB000_0000 + (v << 8), int'(tbl[v].len) + 1);
      end
      bus.s_arvalid = '0;
      bus.s_awvalid = '0;
    end

    // Single 16-beat read from requester 0
    bus.s_arlen   = {8'd15, 8'd15};
    bus.s_arvalid = 2'b01;
    tick();
    read_txn(0, 32'h0000_1000, 8'd15, 32'hC000_0000, 0, -1);
    check_rd(0, 32'hC000_0000, 16);
    chk("single_rd1_quiet", rq1.size(), 0);

    // Write-back of requester 1 goes ahead of its own refill
    bus.s_awlen   = {8'd15, 8'd15};
    bus.s_arlen   = {8'd1, 8'd1};
    bus.s_arvalid = 2'b10;
    bus.s_awvalid = 2'b10;
    tick();
    write_txn(1, 32'h0000_2040, 8'd15, 32'hD000_0000, 1'b0);
    chk("wb_gap_arvalid", bus.m_arvalid, 0);
    tick();
    read_txn(1, 32'h0000_1100, 8'd1, 32'hD100_0000, 0, -1);
    check_rd(1, 32'hD100_0000, 2);

    // Backpressure: toggling wready, then rready held low for 3 cycles
    bus.s_awlen   = {8'd3, 8'd3};
    bus.s_awvalid = 2'b01;
    tick();
    write_txn(0, 32'h0000_2000, 8'd3, 32'hE000_0000, 1'b1);
    bus.s_arlen   = {8'd3, 8'd3};
    bus.s_arvalid = 2'b01;
    tick();
    read_txn(0, 32'h0000_1000, 8'd3, 32'hE100_0000, 3, -1);
    check_rd(0, 32'hE100_0000, 4);

    // Reset in the middle of a read burst
    bus.s_arlen   = {8'd15, 8'd15};
    bus.s_arvalid = 2'b10;
    tick();
    read_txn(1, 32'h0000_1100, 8'd15, 32'hF000_0000, 0, 5);
    chk("mid_rst_beats", rq1.size(), 5);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_grant", grant_id, 0);
    chk("mid_rst_m_rready", bus.m_rready, 0);
    chk("mid_rst_s_rvalid", bus.s_rvalid, 0);
    chk("mid_rst_s_arready", bus.s_arready, 0);
    chk("mid_rst_s_awready", bus.s_awready, 0);
    chk("mid_rst_s_wready", bus.s_wready, 0);
    chk("mid_rst_s_bvalid", bus.s_bvalid, 0);
    bus.m_rvalid  = 1'b0;
    bus.m_rlast   = 1'b0;
    bus.s_rready  = '0;
    bus.s_arvalid = '0;
    rq1.delete();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    tick();

    // Contention after reset: requester 0 first, then 1 after one IDLE cycle
    bus.s_arlen   = {8'd3, 8'd3};
    bus.s_arvalid = 2'b11;
    tick();
    read_txn(0, 32'h0000_1000, 8'd3, 32'h1200_0000, 0, -1);
    chk("cont_gap_arvalid", bus.m_arvalid, 0);
    chk("cont_gap_grant", grant_id, 0);
    tick();
    read_txn(1, 32'h0000_1100, 8'd3, 32'h1300_0000, 0, -1);
    check_rd(0, 32'h1200_0000, 4);
    check_rd(1, 32'h1300_0000, 4);

    // Fairness: both always requesting, grants must alternate 0,1,0,1,...
    bus.s_arlen = {8'd0, 8'd0};
    for (int t = 0; t < 8; t++) begin
      bus.s_arvalid = 2'b11;
      tick();
      read_txn(t % 2, ar_addr(t % 2), 8'd0, 32'h2000_0000 + t, 0, -1);
      check_rd(t % 2, 32'h2000_0000 + t, 1);
    end
    bus.s_arvalid = '0;
    tick();
    chk("end_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
